// File: rtl/demux_dispatcher.sv
// ============================================================================
// Module   : demux_dispatcher
// Brief    : 1-to-4 word dispatcher with a small FIFO and valid/ready
//            handshake per output channel. Optional per-channel delivery
//            counters are enabled by defining DEMUX_DISPATCH_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_dispatcher #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [15:0]      count0,
  output logic [15:0]      count1,
  output logic [15:0]      count2,
  output logic [15:0]      count3
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]       full;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [WIDTH-1:0] head [4];
  logic [15:0]      cnt  [4];

  // Fullness is sampled before any same-cycle pop: no bypass path.
  assign in_ready = !reset && !flush && !full[in_dest];

  generate
    for (genvar k = 0; k < 4; k++) begin : g_ch
      logic [AW-1:0]    wr_ptr;
      logic [AW-1:0]    rd_ptr;
      logic [AW:0]      occ;
      logic [WIDTH-1:0] mem [DEPTH];

      assign full[k]      = (occ == (AW+1)'(DEPTH));
      assign out_valid[k] = (occ != '0);
      assign push[k]      = in_valid && in_ready && (in_dest == 2'(k));
      assign pop[k]       = out_valid[k] && out_ready[k];
      assign head[k]      = out_valid[k] ? mem[rd_ptr] : '0;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          occ    <= '0;
        end else if (flush) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          occ    <= '0;
        end else begin
          if (push[k]) wr_ptr <= wr_ptr + AW'(1);
          if (pop[k])  rd_ptr <= rd_ptr + AW'(1);
          if (push[k] && !pop[k])      occ <= occ + (AW+1)'(1);
          else if (pop[k] && !push[k]) occ <= occ - (AW+1)'(1);
        end
      end

      // Storage needs no reset: head is masked to zero whenever empty.
      always_ff @(posedge clk) begin
        if (push[k]) mem[wr_ptr] <= in_data;
      end

`ifdef DEMUX_DISPATCH_COUNT_EN
      logic [15:0] dcount;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)       dcount <= '0;
        else if (flush)  dcount <= '0;
        else if (pop[k]) dcount <= dcount + 16'd1;
      end
      assign cnt[k] = dcount;
`else
      assign cnt[k] = '0;
`endif
    end
  endgenerate

  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];
  assign count0    = cnt[0];
  assign count1    = cnt[1];
  assign count2    = cnt[2];
  assign count3    = cnt[3];

endmodule

`default_nettype wire

// File: tb/tb_demux_dispatcher.sv
// ============================================================================
// Module   : tb_demux_dispatcher
// Brief    : Self-checking bench for demux_dispatcher against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_dispatcher;

  localparam int WIDTH = 64;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic [3:0]       out_valid, out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [15:0]      count0, count1, count2, count3;

  demux_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .count0(count0), .count1(count1), .count2(count2), .count3(count3)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] od [4];
  logic [15:0]      oc [4];
  always_comb begin
    od[0] = out_data0; od[1] = out_data1; od[2] = out_data2; od[3] = out_data3;
    oc[0] = count0;    oc[1] = count1;    oc[2] = count2;    oc[3] = count3;
  end

  // Reference model: one queue per channel plus delivery tallies.
  logic [WIDTH-1:0] mq [4][$];
  logic [15:0]      mcount [4];
  logic [WIDTH-1:0] rx3 [$];
  int asserts = 0;
  int fails   = 0;

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mcount[k] = 16'd0;
    end
  endtask

  // One clock cycle: drive at negedge, check before posedge, advance model.
  task automatic step(input logic v, input logic [1:0] d, input logic [WIDTH-1:0] x,
                      input logic [3:0] rdy, input logic fl, output logic acc);
    logic             exp_rdy;
    logic [WIDTH-1:0] exp_d;
    in_valid = v; in_dest = d; in_data = x; out_ready = rdy; flush = fl;
    #1;
    exp_rdy = !fl && (mq[d].size() < DEPTH);
    asserts++;
    if (in_ready !== exp_rdy) begin
      fails++;
      $display("FAIL in_ready t=%0t dest=%0d got %b want %b", $time, d, in_ready, exp_rdy);
    end
    for (int k = 0; k < 4; k++) begin
      exp_d = (mq[k].size() != 0) ? mq[k][0] : '0;
      asserts++;
      if (out_valid[k] !== (mq[k].size() != 0)) begin
        fails++;
        $display("FAIL out_valid[%0d] t=%0t got %b want %b", k, $time, out_valid[k], mq[k].size() != 0);
      end
      asserts++;
      if (od[k] !== exp_d) begin
        fails++;
        $display("FAIL out_data%0d t=%0t got %h want %h", k, $time, od[k], exp_d);
      end
      asserts++;
      if (oc[k] !== mcount[k]) begin
        fails++;
        $display("FAIL count%0d t=%0t got %0d want %0d", k, $time, oc[k], mcount[k]);
      end
    end
    acc = v && exp_rdy;
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (rdy[k] && mq[k].size() != 0) begin
          if (k == 3) rx3.push_back(mq[k][0]);
          void'(mq[k].pop_front());
`ifdef DEMUX_DISPATCH_COUNT_EN
          mcount[k] = mcount[k] + 16'd1;
`endif
        end
      end
      if (acc) mq[d].push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] rdy, input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, rdy, 1'b0, a);
  endtask

  task automatic test_reset();
    asserts++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state out_valid=%b in_ready=%b want 0000/0", out_valid, in_ready);
    end
    asserts++;
    if ((out_data0 | out_data1 | out_data2 | out_data3) !== '0 ||
        (count0 | count1 | count2 | count3) !== 16'd0) begin
      fails++;
      $display("FAIL reset_data got data/count nonzero, want 0");
    end
    reset = 1'b0;
    model_clear();
    idle(4'b1111, 1);
  endtask

  task automatic test_routing();
    logic a;
    for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 64'(1 << k), 4'b1111, 1'b0, a);
    idle(4'b1111, 2);
  endtask

  task automatic test_backpressure();
    logic a;
    int   got;
    got = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd2, 64'h200 + 64'(i), 4'b1011, 1'b0, a);
      if (a) got++;
    end
    asserts++;
    if (got != 2) begin
      fails++;
      $display("FAIL backpressure_accepts got %0d want 2", got);
    end
    step(1'b1, 2'd0, 64'hA0, 4'b1011, 1'b0, a);
    asserts++;
    if (a !== 1'b1) begin
      fails++;
      $display("FAIL isolation dest0 accept got %b want 1", a);
    end
    idle(4'b1111, 3);
  endtask

  task automatic test_full_pop();
    logic a;
    step(1'b1, 2'd1, 64'h11, 4'b0000, 1'b0, a);
    step(1'b1, 2'd1, 64'h12, 4'b0000, 1'b0, a);
    step(1'b1, 2'd1, 64'h13, 4'b0010, 1'b0, a);
    asserts++;
    if (a !== 1'b0) begin
      fails++;
      $display("FAIL full_pop push refused got %b want 0", a);
    end
    step(1'b1, 2'd1, 64'h13, 4'b0000, 1'b0, a);
    asserts++;
    if (a !== 1'b1) begin
      fails++;
      $display("FAIL full_pop next push got %b want 1", a);
    end
    asserts++;
    if (mq[1].size() != 2) begin
      fails++;
      $display("FAIL full_pop occupancy got %0d want 2", mq[1].size());
    end
    idle(4'b1111, 3);
  endtask

  task automatic test_wrap();
    logic a;
    int   v;
    v = 0;
    rx3.delete();
    for (int c = 0; c < 40 && (v < 10 || mq[3].size() != 0); c++) begin
      step(v < 10, 2'd3, 64'(v), {c[0], 3'b000}, 1'b0, a);
      if (a) v++;
    end
    asserts++;
    if (rx3.size() != 10) begin
      fails++;
      $display("FAIL wrap received count got %0d want 10", rx3.size());
    end
    for (int i = 0; i < rx3.size() && i < 10; i++) begin
      asserts++;
      if (rx3[i] !== 64'(i)) begin
        fails++;
        $display("FAIL wrap order idx %0d got %0d want %0d", i, rx3[i], i);
      end
    end
  endtask

  task automatic test_flush_reset();
    logic a;
    step(1'b1, 2'd0, 64'hF0, 4'b0000, 1'b0, a);
    step(1'b1, 2'd0, 64'hF1, 4'b0000, 1'b0, a);
    step(1'b1, 2'd0, 64'hF2, 4'b0001, 1'b1, a);
    idle(4'b0000, 1);
    step(1'b1, 2'd0, 64'hE0, 4'b0000, 1'b0, a);
    step(1'b1, 2'd0, 64'hE1, 4'b0000, 1'b0, a);
    #2 reset = 1'b1;
    #1;
    asserts++;
    if (out_valid !== 4'b0000 || out_data0 !== '0 || count0 !== 16'd0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL async_reset out_valid=%b out_data0=%h count0=%0d in_ready=%b want 0",
               out_valid, out_data0, count0, in_ready);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    idle(4'b1111, 1);
  endtask

  task automatic deliver2(input int n);
    logic a;
    int   sent;
    sent = 0;
    while (sent < n) begin
      step(1'b1, 2'd2, 64'(sent), 4'b1111, 1'b0, a);
      if (a) sent++;
    end
    idle(4'b1111, 2);
  endtask

  task automatic test_counter();
    logic a;
    logic [15:0] e;
    step(1'b0, 2'd0, '0, 4'b0000, 1'b1, a);
    deliver2(5);
`ifdef DEMUX_DISPATCH_COUNT_EN
    e = 16'd5;
`else
    e = 16'd0;
`endif
    asserts++;
    if (count2 !== e || count0 !== 16'd0 || count1 !== 16'd0 || count3 !== 16'd0) begin
      fails++;
      $display("FAIL counter5 count2=%0d (want %0d) others %0d/%0d/%0d want 0",
               count2, e, count0, count1, count3);
    end
`ifdef DEMUX_DISPATCH_COUNT_EN
    step(1'b0, 2'd0, '0, 4'b0000, 1'b1, a);
    deliver2(65535);
    asserts++;
    if (count2 !== 16'hFFFF) begin
      fails++;
      $display("FAIL counter_max got %0d want 65535", count2);
    end
    deliver2(1);
    asserts++;
    if (count2 !== 16'd0) begin
      fails++;
      $display("FAIL counter_wrap got %0d want 0", count2);
    end
`endif
  endtask

  task automatic test_random();
    logic a;
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           {$urandom, $urandom}, 4'($urandom), 1'($urandom_range(0, 49) == 0), a);
    idle(4'b1111, 3);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = 2'd0;
    out_ready = 4'b0000;
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    test_routing();
    test_backpressure();
    test_full_pop();
    test_wrap();
    test_flush_reset();
    test_random();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

`default_nettype wire
